// File: rtl/instr_issuer_if.sv
// Host-load and processor-bus signal bundle for instr_issuer.
// slave = the issuer's view, master = the host/processor side.
interface instr_issuer_if #(
    parameter int AW = 3
);
    logic          load_valid;
    logic [7:0]    load_byte;
    logic          load_ready;
    logic          prog_clear;
    logic          start;
    logic [15:0]   inst_out;
    logic          inst_valid;
    logic [7:0]    alu_result;
    logic          alu_zero;
    logic [7:0]    result;
    logic          result_zero;
    logic          result_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   prog_len;

    modport slave (
        input  load_valid, load_byte, prog_clear, start, alu_result, alu_zero,
        output load_ready, inst_out, inst_valid, result, result_zero,
               result_valid, busy, done, prog_len
    );

    modport master (
        output load_valid, load_byte, prog_clear, start, alu_result, alu_zero,
        input  load_ready, inst_out, inst_valid, result, result_zero,
               result_valid, busy, done, prog_len
    );
endinterface

// File: rtl/instr_issuer.sv
// Program sequencer: byte-serial program load, then issue/wait/capture per entry.
// Define ZERO_SKIP_EN to skip opcode 3'b111 entries unless the last result was zero.
module instr_issuer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int RES_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    instr_issuer_if.slave bus
);
    localparam int CW = $clog2(RES_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   len_q;
    logic          half_q;
    logic [7:0]    low_q;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   inst_q;
    logic [7:0]    result_q;
    logic          zero_q;
    logic          rvld_q;
    logic [15:0]   cur_inst;
    logic          byte_acc;
    logic          start_ok;
    logic          last_entry;
    logic          wait_end;
    logic          skip;
    logic          issue_go;

    assign cur_inst   = mem[pc_q];
    assign byte_acc   = bus.load_valid && bus.load_ready && !bus.prog_clear;
    assign start_ok   = (state_q == S_IDLE) && bus.start && (len_q != '0) && !half_q;
    assign last_entry = (({1'b0, pc_q}) + (AW+1)'(1)) == len_q;
    assign wait_end   = (state_q == S_WAIT) && (cnt_q == CW'(1));
    assign issue_go   = (state_q == S_ISSUE) && !skip;

`ifdef ZERO_SKIP_EN
    logic last_zero_q;

    always_ff @(posedge clk) begin
        if (rst)           last_zero_q <= 1'b0;
        else if (start_ok) last_zero_q <= 1'b0;
        else if (wait_end) last_zero_q <= bus.alu_zero;
    end

    // Conditional entries only go out when the previous result was zero.
    assign skip = (state_q == S_ISSUE) && (cur_inst[2:0] == 3'b111) && !last_zero_q;
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok) state_d = S_ISSUE;
            S_ISSUE: if (skip) state_d = last_entry ? S_DONE : S_ISSUE;
                     else      state_d = S_WAIT;
            S_WAIT:  if (wait_end) state_d = last_entry ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
        bus.done       = (state_q == S_DONE);
        bus.inst_valid = issue_go;
        bus.inst_out   = issue_go ? cur_inst : inst_q;
        bus.load_ready = (state_q == S_IDLE) && (len_q < (AW+1)'(DEPTH)) && !bus.start && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            half_q <= 1'b0;
            pc_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if ((state_q == S_IDLE) && bus.prog_clear) begin
                len_q  <= '0;
                half_q <= 1'b0;
            end else if (byte_acc) begin
                half_q <= !half_q;
                if (half_q) len_q <= len_q + (AW+1)'(1);
            end
            if (start_ok)
                pc_q <= '0;
            else if ((skip || wait_end) && !last_entry)
                pc_q <= pc_q + AW'(1);
            if (state_q == S_ISSUE)     cnt_q <= CW'(RES_LAT);
            else if (state_q == S_WAIT) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Program storage survives reset; only the length bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (byte_acc && !half_q) low_q <= bus.load_byte;
        if (byte_acc && half_q)  mem[len_q[AW-1:0]] <= {bus.load_byte, low_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            rvld_q   <= 1'b0;
        end else begin
            if (issue_go) inst_q <= cur_inst;
            rvld_q <= wait_end;
            if (wait_end) begin
                result_q <= bus.alu_result;
                zero_q   <= bus.alu_zero;
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.result_zero  = zero_q;
    assign bus.result_valid = rvld_q;
    assign bus.prog_len     = len_q;
endmodule

// File: doc/instr_issuer.md
# instr_issuer

- Program sequencer that drives the 16-bit instruction bus of the tiny processor and collects its results.
- A host loads a short program byte-serially, low byte first, into an internal instruction buffer, then pulses `start`.
- The block issues each instruction and holds it stable for the processor's result latency. It captures the 8-bit ALU result and zero flag, and reports completion.
- It sits between the host load port and the processor's instruction inputs (`inst[7:0]` on the dedicated inputs, `inst[15:8]` on the IO pins).

## Interface

Parameters:
- `DEPTH`, 8: number of 16-bit program entries; power of two, ≥2.
- `AW`, 3: log2(DEPTH).
- `RES_LAT`, 1: cycles from instruction issue to a valid `alu_result`/`alu_zero`; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  host byte strobe.
- `load_byte`  in  8  program byte; even bytes = `inst[7:0]`, odd bytes = `inst[15:8]`.
- `load_ready`  out  1  byte accepted on `load_valid && load_ready`.
- `prog_clear`  in  1  in IDLE: empty the buffer.
- `start`  in  1  run the loaded program.
- `inst_out`  out  16  instruction to the processor.
- `inst_valid`  out  1  one-cycle strobe marking a new instruction on `inst_out`.
- `alu_result`  in  8  processor result.
- `alu_zero`  in  1  processor zero flag.
- `result`  out  8  captured result.
- `result_zero`  out  1  captured zero flag.
- `result_valid`  out  1  one-cycle strobe, new capture.
- `busy`  out  1  program executing.
- `done`  out  1  one-cycle pulse after the last entry completes.
- `prog_len`  out  AW+1  number of complete words loaded.

## Operation

- Reset (`rst` high at an edge) takes effect at that edge:
  - State → IDLE.
  - `prog_len`, half-word flag, `pc`, wait counter → 0.
  - `inst_out`, `inst_valid`, `result`, `result_zero`, `result_valid`, `busy`, `done` → 0.
  - Memory contents are not cleared.
- `load_ready` = IDLE && `prog_len`<DEPTH && !`start` && !`rst`.
- Loading:
  - Even byte → low-half holding register; set the half flag.
  - Odd byte → writes `{load_byte, low}` to entry `prog_len`, increments `prog_len`, clears the half flag.
- `prog_clear` in IDLE → `prog_len`=0 and half flag cleared; it takes priority over a same-cycle byte. It is ignored outside IDLE.
- `start` is honoured only in IDLE with `prog_len`≠0 and half flag clear; otherwise it is ignored.
- Start also clears `pc` and the last-zero register.
- States:
  - IDLE: honoured `start` → ISSUE.
  - ISSUE (1 cycle):
    - `inst_out`=mem[`pc`], `inst_valid`=1.
    - Wait counter=RES_LAT.
    - → WAIT.
  - WAIT (RES_LAT cycles):
    - `inst_out` held, `inst_valid`=0.
    - In the final cycle, `alu_result`/`alu_zero` are registered into `result`/`result_zero`, and last-zero is updated.
    - `result_valid` is high in the following cycle.
    - If `pc`=`prog_len`−1 → DONE; else `pc`++ → ISSUE.
  - DONE (1 cycle): `done`=1 → IDLE.
- `busy`=1 in ISSUE and WAIT.
- The program is retained after completion; `start` re-runs it.
- `inst_out` keeps the last issued word in IDLE and DONE.

## Timing

- Start accepted at the edge ending cycle s.
- Entry k is issued in cycle s+1+k·(1+RES_LAT).
- Its `result_valid` occurs in cycle s+1+(k+1)(1+RES_LAT), coinciding with the next ISSUE or with DONE.
- `done` occurs in cycle s+1+N·(1+RES_LAT), where N=`prog_len`.
- Load throughput: one byte per cycle.
- Full buffer: `load_ready` drops the cycle after the 2·DEPTH-th byte.
- `pc` does not wrap; execution stops at `prog_len`−1.

## Configuration

- `ZERO_SKIP_EN` defined:
  - An entry whose opcode field `inst[2:0]`=3'b111 is conditional.
  - In ISSUE it is issued only if last-zero=1.
  - Otherwise: `inst_valid` stays 0, no WAIT, no capture. The skip consumes one cycle, then → ISSUE of `pc`+1, or DONE if it was the last entry.
- Undefined: every entry is issued unconditionally, and opcode 3'b111 has no special meaning.

## Test plan

- Load 0x33,0x04,0x0B,0x09, start → `prog_len`=2.
  - `inst_out`=0x0433 with `inst_valid` in s+1; 0x090B in s+3.
  - Bench returns 0x05, then 0x00 → `result`=0x05/zero 0 in s+3, then 0x00/zero 1 in s+5.
  - `done` in s+5, `busy` low in s+5.
- Load 16 bytes (DEPTH=8) → `prog_len`=8 and `load_ready`=0. A 17th byte is ignored.
- Load 3 bytes, start → ignored, `busy`=0. Then `prog_clear` → `prog_len`=0; start → ignored.
- Assert `rst` in s+2 of the first test → following cycle: `busy`=0, `inst_valid`=0, `result`=0, `prog_len`=0, and no `done`.
- `ZERO_SKIP_EN`, program 0x0433, 0x0437, 0x090B, first result 0x05:
  - Entry 1 is skipped, with no `inst_valid` in s+3.
  - 0x090B is issued in s+4; `done` in s+6.
- `ZERO_SKIP_EN`, same program, first result 0x00 → 0x0437 is issued in s+3 and `done` occurs in s+7.
